// File: rtl/sd_cmd_seq_engine.sv
// SD host command/data sequencer: issues 48-bit command frames with response timeout
// and automatic retry, and paces single/multi-block data transfers toward the PHY.

module sd_cmd_seq_engine #(
    parameter int NUM_FUNCS    = 8,
    parameter int FUNC_W       = 3,
    parameter int BLOCK_SIZE_W = 12,
    parameter int TIMEOUT_W    = 16,
    parameter int MAX_RETRIES  = 2,
    parameter int RETRY_W      = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_crc_enable,
    input  logic [TIMEOUT_W-1:0]              i_timeout,
    input  logic [31:0]                       i_block_sleep_count,
    input  logic                              i_cmd_en,
    input  logic [5:0]                        i_cmd,
    input  logic [31:0]                       i_cmd_arg,
    input  logic                              i_rsp_long,
    output logic                              o_cmd_finished,
    output logic [7:0]                        o_error,
    output logic                              o_error_flag,
    output logic [RETRY_W-1:0]                o_retry_count,
    output logic [127:0]                      o_rsp,
    output logic                              o_phy_cmd_en,
    output logic [39:0]                       o_phy_cmd,
    output logic [7:0]                        o_phy_rsp_len,
    input  logic                              i_phy_rsp_finished,
    input  logic [135:0]                      i_phy_rsp,
    input  logic                              i_phy_crc_bad,
    input  logic                              i_data_txrx,
    input  logic                              i_data_block_mode,
    input  logic [23:0]                       i_data_size,
    input  logic [FUNC_W-1:0]                 i_func_addr,
    input  logic [NUM_FUNCS*BLOCK_SIZE_W-1:0] i_func_block_sizes,
    output logic                              o_data_txrx_finished,
    output logic                              o_data_crc_error,
    output logic [23:0]                       o_blocks_done,
    output logic                              o_data_activate,
    input  logic                              i_data_finished,
    input  logic                              i_data_crc_err,
    output logic [BLOCK_SIZE_W-1:0]           o_data_byte_count
);

    typedef enum logic [2:0] {
        CMD_IDLE, CMD_ISSUE, CMD_WAIT_RSP, CMD_GAP, CMD_DONE
    } cmd_state_t;

    typedef enum logic [2:0] {
        DAT_IDLE, DAT_START, DAT_ACTIVE, DAT_SLEEP, DAT_DONE
    } dat_state_t;

    cmd_state_t               cmd_state_reg;
    logic [TIMEOUT_W-1:0]     timer_reg;
    logic [RETRY_W-1:0]       retry_reg;
    logic [7:0]               error_reg;
    logic                     error_flag_reg;
    logic [127:0]             rsp_reg;
    logic                     phy_cmd_en_reg;
    logic [39:0]              phy_cmd_reg;
    logic                     cmd_finished_reg;

    dat_state_t               dat_state_reg;
    logic [BLOCK_SIZE_W-1:0]  byte_count_reg;
    logic [23:0]              blocks_done_reg;
    logic                     data_crc_reg;
    logic                     activate_reg;
    logic                     data_finished_reg;
    logic [31:0]              sleep_cnt_reg;

    logic                     rsp_crc_fail;
    logic                     rsp_timeout;
    logic                     attempt_failed;
    logic [7:0]               fail_code;
    logic                     more_blocks;
    logic [BLOCK_SIZE_W-1:0]  byte_count_next;
    logic [BLOCK_SIZE_W-1:0]  func_size [NUM_FUNCS];
    logic                     unused_rsp_bits;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FUNCS; gi = gi + 1) begin : g_func_size
            assign func_size[gi] = i_func_block_sizes[gi*BLOCK_SIZE_W +: BLOCK_SIZE_W];
        end
    endgenerate

    // Only the low 128 response bits are exposed; the rest are framing.
    assign unused_rsp_bits = ^i_phy_rsp[135:128];

    always_comb begin
        rsp_crc_fail    = i_phy_rsp_finished && i_crc_enable && i_phy_crc_bad;
        // A response arriving on the timeout cycle takes precedence.
        rsp_timeout     = !i_phy_rsp_finished && (i_timeout != '0) &&
                          (timer_reg == i_timeout - TIMEOUT_W'(1));
        attempt_failed  = (cmd_state_reg == CMD_WAIT_RSP) && (rsp_crc_fail || rsp_timeout);
        fail_code       = rsp_crc_fail ? 8'h01 : 8'h02;
        more_blocks     = i_data_block_mode &&
                          ((i_data_size == 24'd0) ||
                           (({1'b0, blocks_done_reg} + 25'd1) < {1'b0, i_data_size}));
        byte_count_next = i_data_block_mode ? func_size[i_func_addr]
                                            : i_data_size[BLOCK_SIZE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_state_reg    <= CMD_IDLE;
            timer_reg        <= '0;
            retry_reg        <= '0;
            error_reg        <= 8'h00;
            error_flag_reg   <= 1'b0;
            rsp_reg          <= '0;
            phy_cmd_en_reg   <= 1'b0;
            phy_cmd_reg      <= '0;
            cmd_finished_reg <= 1'b0;
        end else if (!i_cmd_en && cmd_state_reg != CMD_IDLE) begin
            cmd_state_reg    <= CMD_IDLE;
            phy_cmd_en_reg   <= 1'b0;
            cmd_finished_reg <= 1'b0;
        end else begin
            case (cmd_state_reg)
                CMD_IDLE: begin
                    timer_reg        <= '0;
                    retry_reg        <= '0;
                    error_reg        <= 8'h00;
                    error_flag_reg   <= 1'b0;
                    phy_cmd_en_reg   <= 1'b0;
                    cmd_finished_reg <= 1'b0;
                    if (i_cmd_en) begin
                        phy_cmd_reg   <= {2'b01, i_cmd, i_cmd_arg};
                        cmd_state_reg <= CMD_ISSUE;
                    end
                end
                CMD_ISSUE: begin
                    phy_cmd_en_reg <= 1'b1;
                    timer_reg      <= '0;
                    cmd_state_reg  <= CMD_WAIT_RSP;
                end
                CMD_WAIT_RSP: begin
                    if (i_phy_rsp_finished) begin
                        rsp_reg <= i_phy_rsp[127:0];
                    end
                    if (attempt_failed) begin
                        phy_cmd_en_reg <= 1'b0;
                        if (retry_reg < RETRY_W'(MAX_RETRIES)) begin
                            retry_reg     <= retry_reg + RETRY_W'(1);
                            cmd_state_reg <= CMD_GAP;
                        end else begin
                            error_reg        <= fail_code;
                            error_flag_reg   <= 1'b1;
                            cmd_finished_reg <= 1'b1;
                            cmd_state_reg    <= CMD_DONE;
                        end
                    end else if (i_phy_rsp_finished) begin
                        phy_cmd_en_reg   <= 1'b0;
                        error_reg        <= 8'h00;
                        error_flag_reg   <= 1'b0;
                        cmd_finished_reg <= 1'b1;
                        cmd_state_reg    <= CMD_DONE;
                    end else begin
                        timer_reg <= timer_reg + TIMEOUT_W'(1);
                    end
                end
                CMD_GAP: begin
                    cmd_state_reg <= CMD_ISSUE;
                end
                CMD_DONE: begin
                    cmd_state_reg <= CMD_DONE;
                end
                default: begin
                    cmd_state_reg <= CMD_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dat_state_reg     <= DAT_IDLE;
            byte_count_reg    <= '0;
            blocks_done_reg   <= '0;
            data_crc_reg      <= 1'b0;
            activate_reg      <= 1'b0;
            data_finished_reg <= 1'b0;
            sleep_cnt_reg     <= '0;
        end else if (!i_data_txrx && dat_state_reg != DAT_IDLE) begin
            dat_state_reg     <= DAT_IDLE;
            blocks_done_reg   <= '0;
            data_crc_reg      <= 1'b0;
            activate_reg      <= 1'b0;
            data_finished_reg <= 1'b0;
            sleep_cnt_reg     <= '0;
        end else begin
            case (dat_state_reg)
                DAT_IDLE: begin
                    byte_count_reg    <= byte_count_next;
                    blocks_done_reg   <= '0;
                    data_crc_reg      <= 1'b0;
                    activate_reg      <= 1'b0;
                    data_finished_reg <= 1'b0;
                    if (i_data_txrx) begin
                        dat_state_reg <= DAT_START;
                    end
                end
                DAT_START: begin
                    activate_reg  <= 1'b1;
                    dat_state_reg <= DAT_ACTIVE;
                end
                DAT_ACTIVE: begin
                    if (i_data_finished) begin
                        activate_reg <= 1'b0;
                        if (blocks_done_reg != 24'hFFFFFF) begin
                            blocks_done_reg <= blocks_done_reg + 24'd1;
                        end
                        if (i_data_crc_err) begin
                            data_crc_reg      <= 1'b1;
                            data_finished_reg <= 1'b1;
                            dat_state_reg     <= DAT_DONE;
                        end else if (more_blocks) begin
                            sleep_cnt_reg <= '0;
                            dat_state_reg <= DAT_SLEEP;
                        end else begin
                            data_finished_reg <= 1'b1;
                            dat_state_reg     <= DAT_DONE;
                        end
                    end
                end
                DAT_SLEEP: begin
                    // Sleep spans count+1 cycles so the next activation lands at finish+3+count.
                    if (sleep_cnt_reg == i_block_sleep_count) begin
                        dat_state_reg <= DAT_START;
                    end else begin
                        sleep_cnt_reg <= sleep_cnt_reg + 32'd1;
                    end
                end
                DAT_DONE: begin
                    dat_state_reg <= DAT_DONE;
                end
                default: begin
                    dat_state_reg <= DAT_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_finished       = cmd_finished_reg;
    assign o_error              = error_reg;
    assign o_error_flag         = error_flag_reg;
    assign o_retry_count        = retry_reg;
    assign o_rsp                = rsp_reg;
    assign o_phy_cmd_en         = phy_cmd_en_reg;
    assign o_phy_cmd            = phy_cmd_reg;
    assign o_phy_rsp_len        = i_rsp_long ? 8'd136 : 8'd40;
    assign o_data_txrx_finished = data_finished_reg;
    assign o_data_crc_error     = data_crc_reg;
    assign o_blocks_done        = blocks_done_reg;
    assign o_data_activate      = activate_reg;
    assign o_data_byte_count    = byte_count_reg;

endmodule
